// File: rtl/split_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : split_bus_scheduler
// Brief    : Two-master bus arbiter with split/resume parking, ownership
//            timeout and a one-cycle turnaround gap between owners.
// Revision : 1.0
// ============================================================================
module split_bus_scheduler #(
    parameter int TIMEOUT = 255,
    parameter int RR_EN   = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic [1:0] m1_slv,
    input  logic [1:0] m2_slv,
    input  logic       m1_done,
    input  logic       m2_done,
    input  logic       s_split,
    input  logic [2:0] s_resume,
    output logic       m1_gnt,
    output logic       m2_gnt,
    output logic       m1_split,
    output logic       m2_split,
    output logic [1:0] owner,
    output logic [1:0] slv_sel,
    output logic       timeout
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN  = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;
    localparam logic [1:0] c_NO_SLV = 2'd3;
    localparam logic [9:0] c_TMO  = TIMEOUT[9:0];

    logic [1:0] r_state;
    logic [9:0] r_cnt;
    logic       r_m1_gnt;
    logic       r_m2_gnt;
    logic [1:0] r_owner;
    logic [1:0] r_slv_sel;
    logic       r_m1_split;
    logic       r_m2_split;
    logic [1:0] r_m1_park;
    logic [1:0] r_m2_park;
    logic       r_m1_pend;
    logic       r_m2_pend;
    logic       r_last_m1;

    logic       w_owner_done;
    logic       w_end_own;
    logic       w_m1_elig;
    logic       w_m2_elig;
    logic       w_pick_m2;
    logic [3:0] w_resume;

    assign w_owner_done = (r_owner == 2'd1 && m1_done) || (r_owner == 2'd2 && m2_done);
    assign w_end_own    = w_owner_done || s_split || (r_cnt == c_TMO);
    assign w_resume     = {1'b0, s_resume};

    assign w_m1_elig = m1_req && (m1_slv != c_NO_SLV) && !r_m1_split;
    assign w_m2_elig = m2_req && (m2_slv != c_NO_SLV) && !r_m2_split;

    // Resumed master beats a fresh one; otherwise round-robin or fixed m1.
    always_comb begin
        w_pick_m2 = 1'b0;
        if (w_m1_elig && w_m2_elig) begin
            if (r_m1_pend != r_m2_pend)
                w_pick_m2 = r_m2_pend;
            else if (!r_m1_pend)
                w_pick_m2 = (RR_EN != 0) && r_last_m1;
        end else begin
            w_pick_m2 = w_m2_elig;
        end
    end

    // Timeout loses to a same-cycle done or split, and never fires under reset.
    assign timeout = !rstn && (r_state == c_OWN) && (r_cnt == c_TMO)
                     && !w_owner_done && !s_split;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= c_IDLE;
            r_cnt      <= 10'd0;
            r_m1_gnt   <= 1'b0;
            r_m2_gnt   <= 1'b0;
            r_owner    <= 2'd0;
            r_slv_sel  <= c_NO_SLV;
            r_m1_split <= 1'b0;
            r_m2_split <= 1'b0;
            r_m1_park  <= 2'd0;
            r_m2_park  <= 2'd0;
            r_m1_pend  <= 1'b0;
            r_m2_pend  <= 1'b0;
            r_last_m1  <= 1'b0;
        end else begin
            if (r_m1_split && w_resume[r_m1_park]) begin
                r_m1_split <= 1'b0;
                r_m1_pend  <= 1'b1;
            end
            if (r_m2_split && w_resume[r_m2_park]) begin
                r_m2_split <= 1'b0;
                r_m2_pend  <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_m1_elig || w_m2_elig) begin
                        r_state <= c_OWN;
                        r_cnt   <= 10'd1;
                        if (w_pick_m2) begin
                            r_m2_gnt  <= 1'b1;
                            r_owner   <= 2'd2;
                            r_slv_sel <= m2_slv;
                            r_m2_pend <= 1'b0;
                        end else begin
                            r_m1_gnt  <= 1'b1;
                            r_owner   <= 2'd1;
                            r_slv_sel <= m1_slv;
                            r_m1_pend <= 1'b0;
                        end
                    end
                end
                c_OWN: begin
                    if (w_end_own) begin
                        r_state   <= c_GAP;
                        r_cnt     <= 10'd0;
                        r_m1_gnt  <= 1'b0;
                        r_m2_gnt  <= 1'b0;
                        r_owner   <= 2'd0;
                        r_slv_sel <= c_NO_SLV;
                        r_last_m1 <= (r_owner == 2'd1);
                        if (!w_owner_done && s_split) begin
                            if (r_owner == 2'd1) begin
                                r_m1_split <= 1'b1;
                                r_m1_park  <= r_slv_sel;
                            end else begin
                                r_m2_split <= 1'b1;
                                r_m2_park  <= r_slv_sel;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                c_GAP:   r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign m1_gnt   = r_m1_gnt;
    assign m2_gnt   = r_m2_gnt;
    assign m1_split = r_m1_split;
    assign m2_split = r_m2_split;
    assign owner    = r_owner;
    assign slv_sel  = r_slv_sel;

endmodule
`default_nettype wire

// File: doc/split_bus_scheduler.md
SPLIT_BUS_SCHEDULER -- requirements
Module: split_bus_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles one ownership may last (range 1..1023).
REQ-002 SHALL have parameter RR_EN, default 1: 1 = round-robin tie-break, 0 = fixed priority to m1.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  synchronous, active-high reset (name kept, polarity high).
REQ-005 SHALL have ports m1_req, m2_req  in  1  master requests bus, level, held until granted.
REQ-006 SHALL have ports m1_slv, m2_slv  in  2  target slave id of the request (0,1,2 valid; 3 invalid).
REQ-007 SHALL have ports m1_done, m2_done  in  1  one-cycle pulse from owner ending its transaction.
REQ-008 SHALL have port s_split  in  1  one-cycle pulse from addressed slave requesting a split.
REQ-009 SHALL have port s_resume  in  3  per-slave level, slave ready to complete a parked transaction.
REQ-010 SHALL have ports m1_gnt, m2_gnt  out  1  bus granted, registered, at most one high.
REQ-011 SHALL have ports m1_split, m2_split  out  1  master's transaction parked, registered.
REQ-012 SHALL have port owner  out  2  0 none, 1 m1, 2 m2, registered.
REQ-013 SHALL have port slv_sel  out  2  slave id routed to owner; 3 when no owner.
REQ-014 SHALL have port timeout  out  1  one-cycle pulse when ownership forcibly revoked.

Function
REQ-015 SHALL implement FSM states IDLE, OWN, GAP.
REQ-016 SHALL, in IDLE, sample eligible requests each edge; on a win, enter OWN with winner's gnt high from next cycle (1-cycle req-to-gnt latency).
REQ-017 SHALL treat a request as eligible only if req=1, slv!=3 and the master's split flag is 0.
REQ-018 SHALL never grant a request with slv=3; it stays pending without error.
REQ-019 SHALL, when both eligible and RR_EN=1, grant the master that was not last owner; RR_EN=0 grants m1.
REQ-020 SHALL give a resumed master (resume_pend=1) priority over a non-resumed one; both resumed -> m1.
REQ-021 SHALL latch winner's slv into slv_sel at grant and hold it stable for the whole ownership.
REQ-022 SHALL, in OWN, count cycles from 1; done pulse from owner -> GAP, gnt low next cycle.
REQ-023 SHALL ignore done from the non-owner.
REQ-024 SHALL, on s_split in OWN, set owner's split flag, store slave id in its park slot, go GAP.
REQ-025 SHALL, when done and s_split arrive same cycle, treat as done (no park).
REQ-026 SHALL, when count reaches TIMEOUT without done/split, pulse timeout for one cycle, go GAP; done/split in that same cycle take precedence (no timeout pulse).
REQ-027 SHALL spend exactly one cycle in GAP (owner=0, all gnt low, slv_sel=3) then return to IDLE.
REQ-028 SHALL update last-owner on every exit from OWN.
REQ-029 SHALL, each cycle, clear a master's split flag and set its resume_pend when s_resume[park slot]=1; resume_pend clears when that master is granted.
REQ-030 SHALL let split flag clear and IDLE arbitration happen in consecutive cycles (flag clear at edge N, eligible from edge N+1).
REQ-031 SHALL allow both masters parked simultaneously on different or same slave; each resumes independently.
REQ-032 SHALL ignore s_split and s_resume of non-parked slots outside OWN.

Reset
REQ-033 SHALL, with rstn=1 at an edge, force state IDLE, gnt=0, split=0, resume_pend=0, owner=0, slv_sel=3, timeout=0, counter=0, last-owner=m2.
REQ-034 SHALL let reset mid-ownership abort the transaction with no timeout pulse.
REQ-035 SHALL grant nothing in the cycle rstn deasserts; first grant earliest one cycle later.

Verification
REQ-036 Reset release, m1_req=m2_req=1, slv=1 both, RR_EN=1 -> m1_gnt next cycle; m1_done -> GAP -> m2_gnt; owner 1,0,2.
REQ-037 m2 owns slv 2, s_split pulse -> m2_split=1, m2_gnt low; m1 granted after GAP; s_resume=3'b100 -> m2_split=0, m2 wins next tie over m1.
REQ-038 TIMEOUT=4, m1 owns, no done -> timeout pulse in 4th owned cycle, m1_gnt low next cycle, owner=0 one cycle.
REQ-039 m1_slv=3, m1_req=1 for 20 cycles -> m1_gnt never asserted; m2_req later granted normally.
REQ-040 Same-cycle done and s_split from owner -> no split flag set; same-cycle done at TIMEOUT -> no timeout pulse.
REQ-041 rstn=1 during m1 ownership at cycle 3 -> next cycle all outputs at reset values, slv_sel=3.
